// File: rtl/matrix_scroll_feeder_if.sv
// rtl/matrix_scroll_feeder_if.sv - pattern write bus and matrix-driver column bus
interface matrix_scroll_feeder_if;
    logic        WR_EN;
    logic [4:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD;
    logic        IN_CLR;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [4:0]  offset;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA,
        input  column_id, in_column, LOAD, IN_CLR, BUSY, FRAME_DONE, offset
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA,
        output column_id, in_column, LOAD, IN_CLR, BUSY, FRAME_DONE, offset
    );
endinterface

// File: rtl/matrix_scroll_feeder.sv
// rtl/matrix_scroll_feeder.sv - scrolls a 32-column pattern memory into a 16-column matrix driver
module matrix_scroll_feeder #(
    parameter int HOLD_CYCLES = 1000,
    parameter int STEP        = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RUN,
    matrix_scroll_feeder_if.slave  mx
);
    typedef enum logic [2:0] {IDLE, CLEAR, SETUP, STROBE, HOLD} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [4:0]  STEP_W    = 5'(STEP);

    state_t      state, next_state;
    logic        run_en;
    logic [3:0]  col, col_nxt;
    logic [15:0] hold_cnt, hold_cnt_nxt;
    logic        hold_last;
    logic [4:0]  rd_addr;
    logic [15:0] mem [32];

    logic        load_d, in_clr_d, busy_d, frame_done_d;
    logic [4:0]  column_id_q, offset_q;
    logic [15:0] in_column_q;
    logic        load_q, in_clr_q, busy_q, frame_done_q;

    // Reset assertion is immediate; release is seen one edge late so the
    // FSM first moves on the second rising edge after RESET goes high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) run_en <= 1'b0;
        else        run_en <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)      state <= IDLE;
        else if (run_en) state <= next_state;
    end

    assign hold_last = (hold_cnt == HOLD_LAST);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (RUN) next_state = CLEAR;
            CLEAR:   next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = (col == 4'd15) ? HOLD : SETUP;
            HOLD:    if (hold_last) next_state = RUN ? CLEAR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so each strobe is decoded from the state being entered.
    always_comb begin
        col_nxt = col;
        if (state == CLEAR)
            col_nxt = 4'd0;
        else if (state == STROBE && col != 4'd15)
            col_nxt = col + 4'd1;
        hold_cnt_nxt = (state == HOLD && !hold_last) ? hold_cnt + 16'd1 : 16'd0;
        rd_addr      = offset_q + {1'b0, col_nxt};
        load_d       = (next_state == STROBE);
        in_clr_d     = (next_state == CLEAR);
        busy_d       = (next_state != IDLE);
        frame_done_d = (next_state == HOLD) && (hold_cnt_nxt == HOLD_LAST);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            col          <= 4'd0;
            hold_cnt     <= 16'd0;
            column_id_q  <= 5'd0;
            in_column_q  <= 16'd0;
            offset_q     <= 5'd0;
            load_q       <= 1'b0;
            in_clr_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (run_en) begin
            col          <= col_nxt;
            hold_cnt     <= hold_cnt_nxt;
            load_q       <= load_d;
            in_clr_q     <= in_clr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            // Sampled on the same edge a write lands, so a colliding write is not seen.
            if (next_state == SETUP) begin
                column_id_q <= {1'b0, col_nxt};
                in_column_q <= mem[rd_addr];
            end
            if (state == HOLD && hold_last)
                offset_q <= offset_q + STEP_W;
        end
    end

    always_ff @(posedge CLK) begin
        if (mx.WR_EN) mem[mx.WR_ADDR] <= mx.WR_DATA;
    end

    assign mx.column_id  = column_id_q;
    assign mx.in_column  = in_column_q;
    assign mx.LOAD       = load_q;
    assign mx.IN_CLR     = in_clr_q;
    assign mx.BUSY       = busy_q;
    assign mx.FRAME_DONE = frame_done_q;
    assign mx.offset     = offset_q;
endmodule

// File: tb/tb_matrix_scroll_feeder.sv
// tb/tb_matrix_scroll_feeder.sv - randomized bench against a frame-position reference model
module tb_matrix_scroll_feeder;
    localparam int H = 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic RUN   = 1'b0;
    logic RUN31 = 1'b0;

    always #5 CLK = ~CLK;

    matrix_scroll_feeder_if mif ();
    matrix_scroll_feeder_if mif31 ();

    assign mif31.WR_EN   = mif.WR_EN;
    assign mif31.WR_ADDR = mif.WR_ADDR;
    assign mif31.WR_DATA = mif.WR_DATA;

    matrix_scroll_feeder #(.HOLD_CYCLES(H), .STEP(1)) u_dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .mx(mif)
    );

    matrix_scroll_feeder #(.HOLD_CYCLES(H), .STEP(31)) u_dut31 (
        .CLK(CLK), .RESET(RESET), .RUN(RUN31), .mx(mif31)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame is a sequence of positions 0..32+H after its start edge.
    bit          m_busy = 1'b0;
    bit          m_rel  = 1'b0;
    int          m_pos  = 0;
    int          m_off  = 0;
    int          m_cid  = 0;
    logic [15:0] m_col  = '0;
    logic [15:0] mmem [32];

    always @(posedge CLK) begin
        if (mif.WR_EN) mmem[mif.WR_ADDR] <= mif.WR_DATA;
    end

    always @(posedge CLK or negedge RESET) begin : model
        bit busy;
        int pos, off, cid;
        logic [15:0] cv;
        if (!RESET) begin
            m_busy <= 1'b0; m_rel <= 1'b0; m_pos <= 0;
            m_off  <= 0;    m_cid <= 0;    m_col <= '0;
        end else begin
            busy = m_busy; pos = m_pos; off = m_off; cid = m_cid; cv = m_col;
            if (!m_rel) begin
                m_rel <= 1'b1;
            end else if (!busy) begin
                if (RUN) begin busy = 1'b1; pos = 0; end
            end else begin
                if (pos == 32 + H) begin
                    off = (off + 1) % 32;
                    if (RUN) pos = 0;
                    else     busy = 1'b0;
                end else begin
                    pos++;
                end
                if (busy && pos >= 1 && pos <= 31 && (pos % 2) == 1) begin
                    cid = (pos - 1) / 2;
                    cv  = mmem[(off + cid) % 32];
                end
            end
            m_busy <= busy; m_pos <= pos; m_off <= off; m_cid <= cid; m_col <= cv;
        end
    end

    int n_load = 0, n_clr = 0, n_fd = 0, n_busy = 0, n31 = 0;

    always @(negedge CLK) begin
        check("in_clr",     32'(mif.IN_CLR),     32'(m_busy && m_pos == 0));
        check("load",       32'(mif.LOAD),       32'(m_busy && m_pos >= 2 && m_pos <= 32 && (m_pos % 2) == 0));
        check("busy",       32'(mif.BUSY),       32'(m_busy));
        check("frame_done", 32'(mif.FRAME_DONE), 32'(m_busy && m_pos == 32 + H));
        check("column_id",  32'(mif.column_id),  32'(m_cid));
        check("in_column",  32'(mif.in_column),  32'(m_col));
        check("offset",     32'(mif.offset),     32'(m_off));
        if (mif.LOAD)       n_load++;
        if (mif.IN_CLR)     n_clr++;
        if (mif.FRAME_DONE) n_fd++;
        if (mif.BUSY)       n_busy++;
        if (!RESET) begin
            n31 = 0;
        end else if (mif31.FRAME_DONE) begin
            check("off31_at_done", 32'(mif31.offset), 32'((31 * n31) % 32));
            n31++;
        end
    end

    task automatic write_mem(input logic [4:0] a, input logic [15:0] d);
        mif.WR_EN = 1'b1; mif.WR_ADDR = a; mif.WR_DATA = d;
        @(posedge CLK); #1;
        mif.WR_EN = 1'b0;
    endtask

    task automatic clear_counts();
        n_load = 0; n_clr = 0; n_fd = 0; n_busy = 0;
    endtask

    initial begin
        int t;
        logic [15:0] one;
        one = 16'h0001;
        mif.WR_EN = 1'b0; mif.WR_ADDR = '0; mif.WR_DATA = '0;
        @(posedge CLK); #1;
        for (int k = 0; k < 32; k++)
            write_mem(5'(k), (k < 16) ? (one << k) : 16'($urandom));

        // Release with RUN already high: one frame, RUN dropped right after it starts.
        RESET = 1'b1; RUN = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RUN = 1'b0;
        clear_counts();
        repeat (45) @(posedge CLK);
        #1;
        check("single_clr",   32'(n_clr),  32'd1);
        check("single_loads", 32'(n_load), 32'd16);
        check("single_done",  32'(n_fd),   32'd1);
        check("single_len",   32'(n_busy), 32'(1 + 32 + H));

        // Continuous frames with random pattern writes; the STEP=31 copy runs two frames.
        RUN = 1'b1; RUN31 = 1'b1;
        for (int i = 0; i < 930; i++) begin
            mif.WR_EN   = ($urandom_range(0, 3) == 0);
            mif.WR_ADDR = 5'($urandom);
            mif.WR_DATA = 16'($urandom);
            if (i == 40) RUN31 = 1'b0;
            @(posedge CLK); #1;
        end
        mif.WR_EN = 1'b0;
        check("step31_frames", 32'(n31),           32'd2);
        check("step31_offset", 32'(mif31.offset), 32'd30);

        // Stop while column 8 is being loaded.
        t = 0;
        while (!(mif.LOAD && mif.column_id == 5'd8) && t < 100) begin @(negedge CLK); t++; end
        check("tmo_col8", 32'(t < 100), 32'd1);
        @(posedge CLK); #1;
        RUN = 1'b0;
        clear_counts();
        repeat (60) @(posedge CLK);
        #1;
        check("stop_done", 32'(n_fd),     32'd1);
        check("stop_clr",  32'(n_clr),    32'd0);
        check("stop_busy", 32'(mif.BUSY), 32'd0);

        // Asynchronous reset in the middle of a STROBE cycle.
        RUN = 1'b1;
        t = 0;
        while (!mif.LOAD && t < 100) begin @(negedge CLK); t++; end
        check("tmo_strobe", 32'(t < 100), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("arst_column_id",  32'(mif.column_id),  32'd0);
        check("arst_in_column",  32'(mif.in_column),  32'd0);
        check("arst_load",       32'(mif.LOAD),       32'd0);
        check("arst_in_clr",     32'(mif.IN_CLR),     32'd0);
        check("arst_busy",       32'(mif.BUSY),       32'd0);
        check("arst_frame_done", 32'(mif.FRAME_DONE), 32'd0);
        check("arst_offset",     32'(mif.offset),     32'd0);
        @(posedge CLK); #1;
        write_mem(5'd5, 16'h0020);
        RESET = 1'b1;

        // Write column 5 on the very edge its SETUP samples it (offset 0).
        t = 0;
        while (!mif.IN_CLR && t < 10) begin @(negedge CLK); t++; end
        check("tmo_restart", 32'(t < 10), 32'd1);
        repeat (10) @(posedge CLK);
        #1;
        write_mem(5'd5, 16'hFFFF);
        @(negedge CLK);
        check("collide_cid", 32'(mif.column_id), 32'd5);
        check("collide_old", 32'(mif.in_column), 32'h0020);
        t = 0;
        while (!(mif.LOAD && mif.column_id == 5'd4 && mif.offset == 5'd1) && t < 100) begin
            @(negedge CLK); t++;
        end
        check("tmo_next", 32'(t < 100), 32'd1);
        check("collide_new", 32'(mif.in_column), 32'hFFFF);
        @(posedge CLK); #1;
        RUN = 1'b0;
        repeat (60) @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
